// File: rtl/lfsr_lock_monitor.sv
// PRBS link-health monitor: debounces the checker lock flag into a link state,
// keeps saturating loss/unlock statistics, measures acquisition time and raises
// a sticky timeout when lock is not acquired in time.
module lfsr_lock_monitor #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STABLE_N = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_lock,
    input  logic             i_clear,
    output logic [1:0]       o_state,
    output logic             o_locked,
    output logic             o_timeout,
    output logic             o_loss_pulse,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [CNT_W-1:0] o_unlock_cnt,
    output logic [CNT_W-1:0] o_acq_time
);

    typedef enum logic [1:0] {
        StAcquire = 2'd0,
        StConfirm = 2'd1,
        StLocked  = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam int unsigned StableW = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);

    localparam logic [CNT_W-1:0]   CntMax       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntOne       = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TimeoutVal   = CNT_W'(TIMEOUT);
    localparam logic [StableW-1:0] StableOne    = StableW'(1);
    localparam logic [StableW-1:0] StableTarget = StableW'(STABLE_N);

    state_e             state_q, state_d;
    logic [StableW-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   acq_time_q, acq_time_d;
    logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]   unlock_cnt_q, unlock_cnt_d;
    logic               timeout_q, timeout_d;
    logic               loss_pulse_q, loss_pulse_d;
    logic               locked_q, locked_d;

    logic [CNT_W-1:0]   timer_inc;
    logic [StableW-1:0] stable_next;

    // Next-state, statistics and output decode.
    always_comb begin
        state_d      = state_q;
        stable_d     = stable_q;
        timer_d      = timer_q;
        acq_time_d   = acq_time_q;
        loss_cnt_d   = loss_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        timeout_d    = timeout_q;
        loss_pulse_d = 1'b0;
        stable_next  = stable_q;
        timer_inc    = (timer_q == CntMax) ? timer_q : timer_q + CntOne;

        if (i_clear) begin
            state_d      = StAcquire;
            stable_d     = '0;
            timer_d      = '0;
            acq_time_d   = '0;
            loss_cnt_d   = '0;
            unlock_cnt_d = '0;
            timeout_d    = 1'b0;
        end else if (i_valid) begin
            if (!i_lock && unlock_cnt_q != CntMax) begin
                unlock_cnt_d = unlock_cnt_q + CntOne;
            end

            unique case (state_q)
                StAcquire, StConfirm, StTimeout: begin
                    timer_d = timer_inc;
                    if (i_lock) begin
                        stable_next = (state_q == StConfirm) ? stable_q + StableOne : StableOne;
                        if (stable_next == StableTarget) begin
                            state_d    = StLocked;
                            stable_d   = '0;
                            acq_time_d = timer_inc;
                        end else begin
                            state_d  = StConfirm;
                            stable_d = stable_next;
                        end
                    end else begin
                        stable_d = '0;
                        state_d  = (state_q == StTimeout) ? StTimeout : StAcquire;
                    end
                    // A lock acquired on the deadline cycle wins over the timeout.
                    if (state_q != StTimeout && state_d != StLocked &&
                        timer_inc == TimeoutVal) begin
                        state_d   = StTimeout;
                        stable_d  = '0;
                        timeout_d = 1'b1;
                    end
                end
                StLocked: begin
                    if (!i_lock) begin
                        state_d      = StAcquire;
                        stable_d     = '0;
                        loss_pulse_d = 1'b1;
                        // Timer restarts from zero and the losing cycle is the
                        // first unlocked cycle of the new acquisition.
                        timer_d      = CntOne;
                        if (loss_cnt_q != CntMax) begin
                            loss_cnt_d = loss_cnt_q + CntOne;
                        end
                    end
                end
                default: begin
                    state_d = StAcquire;
                end
            endcase
        end

        locked_d = (state_d == StLocked);
    end

    // State and statistics registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StAcquire;
            stable_q     <= '0;
            timer_q      <= '0;
            acq_time_q   <= '0;
            loss_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            timeout_q    <= 1'b0;
            loss_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_q     <= stable_d;
            timer_q      <= timer_d;
            acq_time_q   <= acq_time_d;
            loss_cnt_q   <= loss_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            timeout_q    <= timeout_d;
            loss_pulse_q <= loss_pulse_d;
            locked_q     <= locked_d;
        end
    end

    assign o_state      = state_q;
    assign o_locked     = locked_q;
    assign o_timeout    = timeout_q;
    assign o_loss_pulse = loss_pulse_q;
    assign o_loss_cnt   = loss_cnt_q;
    assign o_unlock_cnt = unlock_cnt_q;
    assign o_acq_time   = acq_time_q;

endmodule

// File: tb/tb_lfsr_lock_monitor.sv
// Scoreboard bench for lfsr_lock_monitor: stimulus pushes expected values tagged
// with the cycle they are due; a monitor pops and compares them on falling edges.
module tb_lfsr_lock_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid = 1'b0;
    logic lock = 1'b0;
    logic clear = 1'b0;

    logic [1:0]  a_state, b_state;
    logic        a_locked, a_timeout, a_pulse;
    logic        b_locked, b_timeout, b_pulse;
    logic [15:0] a_loss, a_unlock, a_acq;
    logic [3:0]  b_loss, b_unlock, b_acq;

    always #5 clk = ~clk;

    lfsr_lock_monitor #(.CNT_W(16), .STABLE_N(4), .TIMEOUT(16)) dut_a (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_lock(lock), .i_clear(clear),
        .o_state(a_state), .o_locked(a_locked), .o_timeout(a_timeout),
        .o_loss_pulse(a_pulse), .o_loss_cnt(a_loss), .o_unlock_cnt(a_unlock),
        .o_acq_time(a_acq)
    );

    lfsr_lock_monitor #(.CNT_W(4), .STABLE_N(4), .TIMEOUT(15)) dut_b (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_lock(lock), .i_clear(clear),
        .o_state(b_state), .o_locked(b_locked), .o_timeout(b_timeout),
        .o_loss_pulse(b_pulse), .o_loss_cnt(b_loss), .o_unlock_cnt(b_unlock),
        .o_acq_time(b_acq)
    );

    typedef struct {
        int    due;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic int actual(input int sel);
        case (sel)
            0: return int'(a_state);
            1: return int'(a_locked);
            2: return int'(a_timeout);
            3: return int'(a_pulse);
            4: return int'(a_loss);
            5: return int'(a_unlock);
            6: return int'(a_acq);
            7: return int'(b_loss);
            8: return int'(b_locked);
            default: return int'(b_state);
        endcase
    endfunction

    task automatic expect_val(input int sel, input int exp, input string name);
        chk_t c;
        c.due = cyc;
        c.sel = sel;
        c.exp = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int s = 0; s <= 6; s++) expect_val(s, 0, $sformatf("%s_sel%0d", tag, s));
    endtask

    // Monitor: pops every expectation due by this falling edge and compares it.
    initial begin
        chk_t c;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                c = sb.pop_front();
                act = actual(c.sel);
                n_checks++;
                if (c.due != cyc || act != c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d (due cycle %0d, now %0d)",
                             c.name, act, c.exp, c.due, cyc);
                end
            end
        end
    end

    task automatic step(input logic v, input logic l, input logic cl);
        @(negedge clk);
        valid = v;
        lock  = l;
        clear = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        expect_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: lock 0 x3 then 1 x4
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        expect_val(0, 0, "t1_state_acquire");
        expect_val(5, 3, "t1_unlock_3");
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 1, "t1_state_confirm");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        expect_val(1, 0, "t1_not_locked_yet");
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 2, "t1_state_locked");
        expect_val(1, 1, "t1_locked");
        expect_val(6, 7, "t1_acq_time");
        expect_val(5, 3, "t1_unlock_final");
        expect_val(4, 0, "t1_loss_0");

        // 2: lock 1,1,0,1,1,1,1
        step(1'b0, 1'b0, 1'b1);
        expect_all_zero("t2_clear");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 1, "t2_confirm");
        step(1'b1, 1'b0, 1'b0);
        expect_val(0, 0, "t2_abort");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        expect_val(0, 2, "t2_locked");
        expect_val(6, 7, "t2_acq_time");
        expect_val(5, 1, "t2_unlock");

        // 3: single-cycle loss then relock
        step(1'b1, 1'b0, 1'b0);
        expect_val(0, 0, "t3_state_acquire");
        expect_val(3, 1, "t3_pulse_high");
        expect_val(4, 1, "t3_loss_1");
        expect_val(5, 2, "t3_unlock");
        step(1'b1, 1'b1, 1'b0);
        expect_val(3, 0, "t3_pulse_low");
        expect_val(0, 1, "t3_confirm");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        expect_val(0, 2, "t3_relocked");
        expect_val(6, 5, "t3_acq_time");

        // 4: timeout after 16 unlocked valid cycles, recovery, clear
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        expect_val(0, 0, "t4_before_timeout");
        expect_val(2, 0, "t4_timeout_low");
        step(1'b1, 1'b0, 1'b0);
        expect_val(0, 3, "t4_state_timeout");
        expect_val(2, 1, "t4_timeout_set");
        expect_val(5, 16, "t4_unlock");
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 1, "t4_recover_confirm");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        expect_val(0, 2, "t4_relocked");
        expect_val(2, 1, "t4_timeout_sticky");
        expect_val(6, 20, "t4_acq_time");
        step(1'b1, 1'b1, 1'b1);
        expect_all_zero("t4_clear");

        // 5: valid toggling, lock garbage on invalid cycles
        step(1'b1, 1'b0, 1'b0);
        expect_val(5, 1, "t5_unlock_1");
        step(1'b0, 1'b1, 1'b0);
        expect_val(0, 0, "t5_ignored_lock");
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 1, "t5_confirm");
        step(1'b0, 1'b0, 1'b0);
        expect_val(0, 1, "t5_frozen");
        expect_val(5, 1, "t5_unlock_frozen");
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_val(0, 1, "t5_still_confirm");
        step(1'b1, 1'b1, 1'b0);
        expect_val(0, 2, "t5_locked");
        expect_val(6, 5, "t5_acq_time");
        step(1'b0, 1'b0, 1'b0);
        expect_val(0, 2, "t5_hold_locked");
        expect_val(3, 0, "t5_no_pulse");

        // 6: loss counter saturation on a 4-bit instance, then async reset
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        expect_val(8, 1, "t6_b_locked");
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        end
        expect_val(7, 15, "t6_b_loss_sat");
        expect_val(9, 2, "t6_b_state_locked");
        expect_val(4, 20, "t6_a_loss_20");
        expect_val(5, 20, "t6_a_unlock_20");
        expect_val(0, 2, "t6_a_locked_pre_reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        expect_all_zero("t6_async_reset");
        expect_val(7, 0, "t6_b_loss_reset");

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
